// File: rtl/memio_pkg.sv
// Shared definitions for the memio_ws wait-state memory model: FSM states,
// wait-count limits and the lane-count helper.
package memio_pkg;

    localparam int MAX_WAIT_STATES = 15;
    localparam int WAIT_CNT_W      = $clog2(MAX_WAIT_STATES + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        READ,
        WRITE,
        DONE
    } memio_state_e;

    // Number of byte lanes on the data bus (1 for 8088, 2 for 8086).
    function automatic int lane_count(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/memio_waitgen.sv
// Wait-state down-counter: loaded on entry to WAIT, done once WAIT_STATES
// cycles have been spent there; abort clears it.
module memio_waitgen
    import memio_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic CLK,
    input  logic RESET,
    input  logic load,
    input  logic abort,
    output logic done
);

    // The first WAIT cycle already counts, so load one less than the total.
    localparam logic [WAIT_CNT_W-1:0] LOAD_VAL =
        WAIT_CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    logic [WAIT_CNT_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET || abort) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/memio_ws.sv
// Byte/word memory on an 8088/8086-style strobe bus with programmable wait
// states. Define MEMIO_PARITY_EN to add per-byte even parity and PERR.
module memio_ws
    import memio_pkg::*;
#(
    parameter int    ADDR_WIDTH  = 20,
    parameter int    DATA_WIDTH  = 8,
    parameter int    BASE_ADDR   = 0,
    parameter int    NUM_BYTES   = 524288,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = "memory_init.mem"
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CS,
    input  logic                  OE_n,
    input  logic                  WR_n,
    input  logic                  BHE_n,
    input  logic [ADDR_WIDTH-1:0] Address,
    inout  wire  [DATA_WIDTH-1:0] Data,
    output logic                  READY,
    output logic                  PERR
);

    localparam int LANES = lane_count(DATA_WIDTH);
    localparam int WORDS = NUM_BYTES / LANES;
    localparam int IDX_W = $clog2(WORDS);
    localparam int LSB   = (LANES == 2) ? 1 : 0;

    localparam logic [ADDR_WIDTH-1:0] BASE_A      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   NUM_BYTES_W = (ADDR_WIDTH + 1)'(NUM_BYTES);

    memio_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  rd_req, wr_req, req_valid;
    logic [IDX_W-1:0]      idx_in, idx_q, rd_idx;
    logic [LANES-1:0]      lane_in, lane_q, rd_lane;
    logic                  is_wr_q;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic                  ready_q;
    logic                  drive_en;
    logic                  wait_load, wait_abort, wait_done;
    logic                  par_err;

    // NOTE: the storage array has no reset; RESET only returns the control
    // path to IDLE and leaves memory contents intact.
    logic [DATA_WIDTH-1:0] mem_q [WORDS];
`ifdef MEMIO_PARITY_EN
    logic [LANES-1:0]      par_q [WORDS];
    logic                  perr_q;
`endif

    initial begin
        for (int w = 0; w < WORDS; w++) begin
            mem_q[w] = '0;
`ifdef MEMIO_PARITY_EN
            par_q[w] = '0;
`endif
        end
    end

    // Request decode: exactly one strobe low inside the decoded window.
    assign offset    = Address - BASE_A;
    assign rd_req    = !OE_n && WR_n;
    assign wr_req    = OE_n && !WR_n;
    assign req_valid = CS && (rd_req || wr_req) && (Address >= BASE_A)
                       && ({1'b0, offset} < NUM_BYTES_W);
    assign idx_in    = offset[LSB +: IDX_W];

    if (LANES == 2) begin : g_lanes16
        assign lane_in = {~BHE_n, ~Address[0]};
    end else begin : g_lanes8
        logic unused_bhe;
        assign unused_bhe = BHE_n;
        assign lane_in    = 1'b1;
    end

    memio_waitgen #(
        .WAIT_STATES(WAIT_STATES)
    ) u_waitgen (
        .CLK  (CLK),
        .RESET(RESET),
        .load (wait_load),
        .abort(wait_abort),
        .done (wait_done)
    );

    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    always_comb begin
        state_d    = state_q;
        wait_load  = 1'b0;
        wait_abort = 1'b0;
        unique case (state_q)
            IDLE: if (req_valid) begin
                if (WAIT_STATES > 0) begin
                    state_d   = WAIT;
                    wait_load = 1'b1;
                end else begin
                    state_d = wr_req ? WRITE : READ;
                end
            end
            WAIT: if (OE_n && WR_n) begin
                state_d    = IDLE;
                wait_abort = 1'b1;
            end else if (wait_done) begin
                state_d = is_wr_q ? WRITE : READ;
            end
            READ, WRITE: state_d = DONE;
            DONE: if (OE_n && WR_n) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read path: from IDLE the live address is used, from WAIT the latched one.
    assign rd_idx  = (state_q == IDLE) ? idx_in : idx_q;
    assign rd_lane = (state_q == IDLE) ? lane_in : lane_q;

    always_comb begin
        rd_d    = '0;
        par_err = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (rd_lane[l]) begin
                rd_d[8*l +: 8] = mem_q[rd_idx][8*l +: 8];
`ifdef MEMIO_PARITY_EN
                par_err = par_err | ((^mem_q[rd_idx][8*l +: 8]) ^ par_q[rd_idx][l]);
`endif
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            rd_q    <= '0;
`ifdef MEMIO_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != WAIT);
            if (state_q == IDLE && req_valid) begin
                idx_q   <= idx_in;
                lane_q  <= lane_in;
                is_wr_q <= wr_req;
            end
            if (state_d == READ) rd_q <= rd_d;
`ifdef MEMIO_PARITY_EN
            perr_q  <= (state_d == READ) && par_err;
`endif
        end
    end

    // Write commits on the edge leaving WRITE; a reset on that edge drops it.
    always_ff @(posedge CLK) begin
        if (!RESET && state_q == WRITE) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_q[l]) begin
                    mem_q[idx_q][8*l +: 8] <= Data[8*l +: 8];
`ifdef MEMIO_PARITY_EN
                    par_q[idx_q][l]        <= ^Data[8*l +: 8];
`endif
                end
            end
        end
    end

    assign drive_en = ((state_q == READ) || (state_q == DONE)) && !OE_n;
    assign Data     = drive_en ? rd_q : 'z;
    assign READY    = ready_q;
`ifdef MEMIO_PARITY_EN
    assign PERR     = perr_q;
`else
    assign PERR     = 1'b0;
`endif

endmodule

// File: tb/tb_memio_ws.sv
// Directed bench for memio_ws: three configurations (8-bit/0 WS, 8-bit/3 WS
// with offset base, 16-bit/0 WS) with a read-expectation scoreboard.
`timescale 1ns/1ps
module tb_memio_ws;
    import memio_pkg::*;

    typedef struct {
        string       tag;
        logic [15:0] data;
        logic        perr;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] ref_mem [int];
    int         total = 0;
    int         bad   = 0;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        cs = 1'b0, oe_n = 1'b1, wr_n = 1'b1, bhe_n = 1'b1;
    logic [19:0] addr = '0;
    int          sel = 0;
    logic        drv_en = 1'b0;
    logic [15:0] drv_val = '0;

    wire  [7:0]  d8, d8w;
    wire  [15:0] d16;
    logic        rdy8, rdy8w, rdy16, perr8, perr8w, perr16;
    logic        obs_ready, obs_perr;
    logic [15:0] obs_data;

    always #5 CLK = ~CLK;

    assign d8  = (drv_en && sel == 0) ? drv_val[7:0] : 'z;
    assign d8w = (drv_en && sel == 1) ? drv_val[7:0] : 'z;
    assign d16 = (drv_en && sel == 2) ? drv_val      : 'z;

    memio_ws #(.ADDR_WIDTH(20), .DATA_WIDTH(8), .BASE_ADDR(0), .NUM_BYTES(256),
               .WAIT_STATES(0), .INIT_FILE("")) u8 (
        .CLK(CLK), .RESET(RESET), .CS(cs && sel == 0), .OE_n(oe_n), .WR_n(wr_n),
        .BHE_n(bhe_n), .Address(addr), .Data(d8), .READY(rdy8), .PERR(perr8));

    memio_ws #(.ADDR_WIDTH(20), .DATA_WIDTH(8), .BASE_ADDR(32'h1000), .NUM_BYTES(256),
               .WAIT_STATES(3), .INIT_FILE("")) u8w (
        .CLK(CLK), .RESET(RESET), .CS(cs && sel == 1), .OE_n(oe_n), .WR_n(wr_n),
        .BHE_n(bhe_n), .Address(addr), .Data(d8w), .READY(rdy8w), .PERR(perr8w));

    memio_ws #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .BASE_ADDR(0), .NUM_BYTES(256),
               .WAIT_STATES(0), .INIT_FILE("")) u16 (
        .CLK(CLK), .RESET(RESET), .CS(cs && sel == 2), .OE_n(oe_n), .WR_n(wr_n),
        .BHE_n(bhe_n), .Address(addr), .Data(d16), .READY(rdy16), .PERR(perr16));

    always_comb begin
        obs_ready = rdy8;
        obs_perr  = perr8;
        obs_data  = {8'h00, d8};
        if (sel == 1) begin
            obs_ready = rdy8w;
            obs_perr  = perr8w;
            obs_data  = {8'h00, d8w};
        end else if (sel == 2) begin
            obs_ready = rdy16;
            obs_perr  = perr16;
            obs_data  = d16;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int key(input int which, input logic [19:0] a);
        return which * 4096 + int'(a[11:0]);
    endfunction

    task automatic model_write(input int which, input logic [19:0] a, input logic [15:0] d,
                               input logic b);
        if (which == 2) begin
            if (!a[0]) ref_mem[key(which, {a[19:1], 1'b0})] = d[7:0];
            if (!b)    ref_mem[key(which, {a[19:1], 1'b1})] = d[15:8];
        end else begin
            ref_mem[key(which, a)] = d[7:0];
        end
    endtask

    function automatic logic [15:0] model_read(input int which, input logic [19:0] a,
                                               input logic b);
        logic [7:0] lo, hi;
        if (which != 2) return {8'h00, ref_mem[key(which, a)]};
        lo = a[0] ? 8'h00 : ref_mem[key(which, {a[19:1], 1'b0})];
        hi = b    ? 8'h00 : ref_mem[key(which, {a[19:1], 1'b1})];
        return {hi, lo};
    endfunction

    // One complete strobe cycle; the strobe is held for WS+2 edges
    // (request, WS waits, READ/WRITE) and released in DONE.
    task automatic access(input int which, input logic wr, input logic [19:0] a,
                          input logic [15:0] d, input logic b, input logic exp_perr,
                          input string tag);
        int   ws;
        int   low;
        exp_t e;
        ws = (which == 1) ? 3 : 0;
        if (!wr) sb_q.push_back('{tag, model_read(which, a, b), exp_perr});
        @(negedge CLK);
        sel = which; addr = a; bhe_n = b; cs = 1'b1;
        if (wr) begin
            drv_val = d; drv_en = 1'b1; wr_n = 1'b0;
        end else begin
            oe_n = 1'b0;
        end
        low = 0;
        for (int c = 0; c < ws + 2; c++) begin
            @(negedge CLK);
            if (obs_ready == 1'b0) low++;
            if (!wr && c == ws) begin
                e = sb_q.pop_front();
                check({e.tag, "_data"}, obs_data, e.data);
                check({e.tag, "_perr"}, 16'(obs_perr), 16'(e.perr));
            end
            if (!wr && c == ws + 1) check({tag, "_perr_done"}, 16'(obs_perr), 16'h0000);
        end
        cs = 1'b0; oe_n = 1'b1; wr_n = 1'b1; drv_en = 1'b0;
        check({tag, "_ready_low"}, 16'(low), 16'(ws));
        if (wr) model_write(which, a, d, b);
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_ready8",  16'(rdy8),  16'h1);
        check("rst_ready8w", 16'(rdy8w), 16'h1);
        check("rst_ready16", 16'(rdy16), 16'h1);
        check("rst_perr",    16'(perr8 | perr8w | perr16), 16'h0);
        check("rst_state",   16'(u8w.state_q), 16'(IDLE));
        check("rst_hiz",     16'(u8.drive_en | u8w.drive_en | u16.drive_en), 16'h0);
        RESET = 1'b0;
        @(negedge CLK);

        // 8-bit, zero wait states
        access(0, 1'b1, 20'h00010, 16'h00A5, 1'b1, 1'b0, "w8_a5");
        access(0, 1'b0, 20'h00010, 16'h0000, 1'b1, 1'b0, "r8_a5");
        access(0, 1'b1, 20'h000FF, 16'h005A, 1'b1, 1'b0, "w8_top");
        access(0, 1'b1, 20'h00080, 16'h00C3, 1'b1, 1'b0, "w8_mid");
        access(0, 1'b0, 20'h000FF, 16'h0000, 1'b1, 1'b0, "r8_top");
        access(0, 1'b0, 20'h00080, 16'h0000, 1'b1, 1'b0, "r8_mid");

        // First address past the window is ignored
        @(negedge CLK);
        sel = 0; addr = 20'h00100; cs = 1'b1; oe_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check("oor_state", 16'(u8.state_q), 16'(IDLE));
            check("oor_hiz",   16'(u8.drive_en), 16'h0);
            check("oor_ready", 16'(rdy8), 16'h1);
        end
        cs = 1'b0; oe_n = 1'b1;

        // 8-bit, three wait states, window based at 0x1000
        access(1, 1'b1, 20'h01040, 16'h003C, 1'b1, 1'b0, "w8w_3c");
        access(1, 1'b0, 20'h01040, 16'h0000, 1'b1, 1'b0, "r8w_3c");

        @(negedge CLK);
        sel = 1; addr = 20'h00FFF; cs = 1'b1; oe_n = 1'b0;
        repeat (2) @(negedge CLK);
        check("below_base_state", 16'(u8w.state_q), 16'(IDLE));
        check("below_base_ready", 16'(rdy8w), 16'h1);
        cs = 1'b0; oe_n = 1'b1;

        // Aborted cycle: strobes released while waiting
        @(negedge CLK);
        sel = 1; addr = 20'h01040; cs = 1'b1; wr_n = 1'b0; drv_val = 16'h0077; drv_en = 1'b1;
        @(negedge CLK);
        check("abort_wait_ready", 16'(rdy8w), 16'h0);
        cs = 1'b0; wr_n = 1'b1; drv_en = 1'b0;
        @(negedge CLK);
        check("abort_ready", 16'(rdy8w), 16'h1);
        check("abort_state", 16'(u8w.state_q), 16'(IDLE));
        access(1, 1'b0, 20'h01040, 16'h0000, 1'b1, 1'b0, "r8w_after_abort");

        // Reset in the middle of a waited write of 0x55
        @(negedge CLK);
        sel = 1; addr = 20'h01040; cs = 1'b1; wr_n = 1'b0; drv_val = 16'h0055; drv_en = 1'b1;
        @(negedge CLK);
        check("rstwait_ready", 16'(rdy8w), 16'h0);
        RESET = 1'b1; cs = 1'b0; wr_n = 1'b1; drv_en = 1'b0;
        @(negedge CLK);
        check("rstwait_state", 16'(u8w.state_q), 16'(IDLE));
        check("rstwait_ready_hi", 16'(rdy8w), 16'h1);
        RESET = 1'b0;
        access(1, 1'b0, 20'h01040, 16'h0000, 1'b1, 1'b0, "r8w_after_reset");

        // 16-bit lanes
        access(2, 1'b1, 20'h00020, 16'hBEEF, 1'b0, 1'b0, "w16_beef");
        access(2, 1'b1, 20'h00021, 16'h1100, 1'b0, 1'b0, "w16_hi11");
        access(2, 1'b0, 20'h00020, 16'h0000, 1'b0, 1'b0, "r16_word");
        access(2, 1'b0, 20'h00020, 16'h0000, 1'b1, 1'b0, "r16_lo_only");
        access(2, 1'b0, 20'h00021, 16'h0000, 1'b0, 1'b0, "r16_hi_only");

`ifdef MEMIO_PARITY_EN
        // Parity: clean read, then a read after a flipped stored parity bit
        access(0, 1'b1, 20'h00030, 16'h0096, 1'b1, 1'b0, "wpar");
        access(0, 1'b0, 20'h00030, 16'h0000, 1'b1, 1'b0, "rpar_ok");
        u8.par_q[48] = ~u8.par_q[48];
        access(0, 1'b0, 20'h00030, 16'h0000, 1'b1, 1'b1, "rpar_err");
`endif

        check("sb_empty", 16'(sb_q.size()), 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memio_ws.md
MEMIO_WS -- requirements
Module: memio_ws

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 20, system address bus width.
REQ-002 SHALL have parameter DATA_WIDTH, 8, data bus width; legal values are 8 (8088) or 16 (8086).
REQ-003 SHALL have parameter BASE_ADDR, 0, first byte address decoded.
REQ-004 SHALL have parameter NUM_BYTES, 524288, decoded window size in bytes; must be a power of 2.
REQ-005 SHALL have parameter WAIT_STATES, 0, READY-low cycles per access; legal range 0..15.
REQ-006 SHALL have parameter INIT_FILE, "memory_init.mem", hex image loaded at start; empty string means no load.
REQ-007 SHALL have port CLK  input  1  clock; all state changes on rising edge.
REQ-008 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-009 SHALL have ports CS input 1 (chip select, active high), OE_n input 1 (read strobe, active low), WR_n input 1 (write strobe, active low) and BHE_n input 1 (high byte enable, active low; ignored when DATA_WIDTH=8).
REQ-010 SHALL have port Address  input  ADDR_WIDTH  byte address.
REQ-011 SHALL have port Data  inout  DATA_WIDTH  tristate data bus.
REQ-012 SHALL have ports READY output 1 (bus ready, high = no wait) and PERR output 1 (read parity error).

Function
REQ-013 SHALL treat a request as valid when CS=1, (Address-BASE_ADDR) < NUM_BYTES, and exactly one of OE_n/WR_n is low; any other combination is ignored.
REQ-014 SHALL implement FSM states IDLE, WAIT, READ, WRITE, DONE.
REQ-015 SHALL go IDLE->WAIT on a valid request when WAIT_STATES>0, otherwise IDLE->READ/WRITE directly; the request type and address are latched at that edge.
REQ-016 SHALL stay in WAIT exactly WAIT_STATES cycles using a down-counter, then enter READ or WRITE.
REQ-017 SHALL drive READY=0 only in WAIT and READY=1 in every other state.
REQ-018 SHALL go WAIT->IDLE with no memory write when both strobes are high in WAIT (aborted cycle).
REQ-019 SHALL drive Data with the latched word in READ and DONE while OE_n=0, and Hi-Z otherwise.
REQ-020 SHALL commit a write at the clock edge leaving WRITE, sampling Data in that cycle; memory SHALL be a clocked array.
REQ-021 SHALL, for DATA_WIDTH=16, use word index = offset>>1, enable the low lane when A0=0 and the high lane when BHE_n=0, and write or drive only enabled lanes (disabled lanes read as 0).
REQ-022 SHALL go READ/WRITE->DONE unconditionally, and DONE->IDLE only when OE_n=1 and WR_n=1, so that one strobe produces exactly one access.
REQ-023 SHALL hold PERR=0 except in a READ cycle whose parity check fails (see REQ-027).

Reset
REQ-024 SHALL, on RESET=1, set state IDLE, wait counter 0, READY=1, PERR=0 and Data Hi-Z at the next edge.
REQ-025 SHALL, when RESET is asserted mid-access (WAIT/WRITE), discard the pending write; memory contents are not cleared.

Configuration
REQ-026 SHALL compile the parity feature in only when macro MEMIO_PARITY_EN is defined.
REQ-027 SHALL, with MEMIO_PARITY_EN defined, store even parity per byte on write and, in READ, set PERR=1 if any enabled lane mismatches; without the macro, no parity storage exists and PERR is tied 0.

Structure
REQ-028 SHALL put the state enum, MAX_WAIT_STATES=15 and a lane-count function in package memio_pkg.
REQ-029 SHALL implement the wait counter in sub-module memio_waitgen (inputs load/abort, output done).

Verification
REQ-030 SHALL check: WAIT_STATES=0, 8-bit, write 0xA5 to 0x00010 then read it -> Data=0xA5 in the cycle after the request, READY never low.
REQ-031 SHALL check: WAIT_STATES=3 read -> READY low exactly 3 cycles, data valid in the next cycle.
REQ-032 SHALL check: 16-bit, write 0xBEEF at 0x00020 with BHE_n=0, then a byte write 0x11 at 0x00021 (A0=1, BHE_n=0) -> a word read returns 0x11EF.
REQ-033 SHALL check: Address = BASE_ADDR+NUM_BYTES with CS=1 -> state stays IDLE, Data Hi-Z, READY=1.
REQ-034 SHALL check: RESET asserted during WAIT of a write of 0x55 -> state IDLE next cycle, memory keeps its old value.
REQ-035 SHALL check, with MEMIO_PARITY_EN: a forced parity bit flip at 0x00030 -> PERR=1 in the READ cycle only.
